// File: rtl/wb_timer_slave.sv
// +--------------------------------------------------------------------------+
// | wb_timer_slave: Wishbone classic slave, 32-bit prescaled timer with      |
// | compare match, auto-reload and level interrupt.            Rev 1.0       |
// +--------------------------------------------------------------------------+
`default_nettype none

module wb_timer_slave #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [3:0]  i_wb_sel,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic        o_irq
);

  localparam logic [2:0] c_ADR_CTRL     = 3'd0;
  localparam logic [2:0] c_ADR_PRESCALE = 3'd1;
  localparam logic [2:0] c_ADR_COUNT    = 3'd2;
  localparam logic [2:0] c_ADR_COMPARE  = 3'd3;
  localparam logic [2:0] c_ADR_STATUS   = 3'd4;

  logic [2:0]                r_ctrl;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [PRESCALE_WIDTH-1:0] r_pcnt;
  logic [31:0]               r_count;
  logic [31:0]               r_compare;
  logic                      r_match;
  logic                      r_ack;
  logic [31:0]               r_rdat;

  logic        w_req;
  logic        w_wr;
  logic        w_rd;
  logic [2:0]  w_word;
  logic        w_tick;
  logic        w_hit;
  logic        w_clr;
  logic [31:0] w_ctrl_m;
  logic [31:0] w_pre_m;
  logic [31:0] w_cnt_m;
  logic [31:0] w_cmp_m;
  logic [31:0] w_rdat;
  logic        w_unused_bits;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  sel);
    f_merge = old_v;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) f_merge[8*i +: 8] = new_v[8*i +: 8];
    end
  endfunction

  // The ack gate makes a held strobe complete every other cycle.
  assign w_req  = i_wb_cyc && i_wb_stb && !r_ack;
  assign w_wr   = w_req && i_wb_we;
  assign w_rd   = w_req && !i_wb_we;
  assign w_word = i_wb_adr[4:2];

  assign w_tick = r_ctrl[0] && (r_pcnt == r_prescale);
  assign w_hit  = (r_count == r_compare);
  assign w_clr  = w_wr && (w_word == c_ADR_STATUS) && i_wb_sel[0] && i_wb_dat[0];

  assign w_ctrl_m = f_merge({29'd0, r_ctrl}, i_wb_dat, i_wb_sel);
  assign w_pre_m  = f_merge(32'(r_prescale), i_wb_dat, i_wb_sel);
  assign w_cnt_m  = f_merge(r_count, i_wb_dat, i_wb_sel);
  assign w_cmp_m  = f_merge(r_compare, i_wb_dat, i_wb_sel);

  assign w_unused_bits = ^{i_wb_adr[31:5], i_wb_adr[1:0], w_ctrl_m, w_pre_m};

  always_comb begin
    w_rdat = 32'd0;
    case (w_word)
      c_ADR_CTRL:     w_rdat = {29'd0, r_ctrl};
      c_ADR_PRESCALE: w_rdat = 32'(r_prescale);
      c_ADR_COUNT:    w_rdat = r_count;
      c_ADR_COMPARE:  w_rdat = r_compare;
      c_ADR_STATUS:   w_rdat = {31'd0, r_match};
      default:        w_rdat = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl     <= 3'd0;
      r_prescale <= '0;
      r_pcnt     <= '0;
      r_count    <= 32'd0;
      r_compare  <= 32'hFFFF_FFFF;
      r_match    <= 1'b0;
      r_ack      <= 1'b0;
      r_rdat     <= 32'd0;
    end else begin
      r_ack  <= w_req;
      r_rdat <= w_rd ? w_rdat : 32'd0;

      if (w_wr && (w_word == c_ADR_CTRL)) r_ctrl <= w_ctrl_m[2:0];
      if (w_wr && (w_word == c_ADR_PRESCALE)) r_prescale <= w_pre_m[PRESCALE_WIDTH-1:0];
      if (w_wr && (w_word == c_ADR_COMPARE)) r_compare <= w_cmp_m;

      if (w_wr && (w_word == c_ADR_PRESCALE)) begin
        r_pcnt <= '0;
      end else if (w_tick || !r_ctrl[0]) begin
        r_pcnt <= '0;
      end else begin
        r_pcnt <= r_pcnt + 1'b1;
      end

      // A bus write to COUNT overrides any increment from a coincident tick.
      if (w_wr && (w_word == c_ADR_COUNT)) begin
        r_count <= w_cnt_m;
      end else if (w_tick) begin
        r_count <= (w_hit && r_ctrl[1]) ? 32'd0 : r_count + 32'd1;
      end

      if (w_tick && w_hit) begin
        r_match <= 1'b1;
      end else if (w_clr) begin
        r_match <= 1'b0;
      end
    end
  end

  assign o_wb_ack = r_ack;
  assign o_wb_dat = r_rdat;
  assign o_irq    = r_match && r_ctrl[2];

endmodule

`default_nettype wire

// File: tb/tb_wb_timer_slave.sv
// +--------------------------------------------------------------------------+
// | tb_wb_timer_slave: directed and randomized bench for wb_timer_slave      |
// | against an in-bench behavioural model.                     Rev 1.0       |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_wb_timer_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'd0;
  logic [31:0] adr = 32'd0, wdat = 32'd0;
  logic [31:0] o_wb_dat;
  logic        o_wb_ack, o_irq;

  int tests = 0;
  int fails = 0;

  wb_timer_slave #(.PRESCALE_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_sel(sel),
    .i_wb_adr(adr), .i_wb_dat(wdat),
    .o_wb_dat(o_wb_dat), .o_wb_ack(o_wb_ack), .o_irq(o_irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  ctrl;
    logic [15:0] pre;
    logic [15:0] pcnt;
    logic [31:0] cnt;
    logic [31:0] cmp;
    logic        match;
    logic        ack;
    logic [31:0] dat;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t m_reset();
    mstate_t r;
    r = '0;
    r.cmp = 32'hFFFF_FFFF;
    return r;
  endfunction

  function automatic logic [31:0] lane_merge(logic [31:0] old_v, logic [31:0] new_v, logic [3:0] s);
    longint mask = 0;
    for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (longint'(255) << (8 * b));
    return 32'((longint'(old_v) & ~mask) | (longint'(new_v) & mask));
  endfunction

  function automatic logic [31:0] reg_value(mstate_t s, int word);
    case (word)
      0: return {29'd0, s.ctrl};
      1: return {16'd0, s.pre};
      2: return s.cnt;
      3: return s.cmp;
      4: return {31'd0, s.match};
      default: return 32'd0;
    endcase
  endfunction

  // Next state of the whole slave after one rising edge, from the register-level rules.
  function automatic mstate_t m_step(mstate_t s, logic c, logic st, logic w, logic [31:0] a,
                                     logic [31:0] d, logic [3:0] se);
    mstate_t n = s;
    bit req = c && st && !s.ack;
    int word = int'(a[4:2]);
    bit tick = s.ctrl[0] && (s.pcnt == s.pre);
    bit set_m = tick && (s.cnt == s.cmp);
    logic [31:0] mg;
    n.ack = req;
    n.dat = (req && !w) ? reg_value(s, word) : 32'd0;
    n.pcnt = (tick || !s.ctrl[0]) ? 16'd0 : 16'(int'(s.pcnt) + 1);
    if (tick) n.cnt = (set_m && s.ctrl[1]) ? 32'd0 : 32'((longint'(s.cnt) + 1) % 64'h1_0000_0000);
    if (set_m) n.match = 1'b1;
    if (req && w) begin
      mg = lane_merge(reg_value(s, word), d, se);
      case (word)
        0: n.ctrl = mg[2:0];
        1: begin n.pre = mg[15:0]; n.pcnt = 16'd0; end
        2: n.cnt = mg;
        3: n.cmp = mg;
        4: if (se[0] && d[0] && !set_m) n.match = 1'b0;
        default: ;
      endcase
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= m_reset();
    else        m <= m_step(m, cyc, stb, we, adr, wdat, sel);
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_ack", {31'd0, o_wb_ack}, {31'd0, m.ack});
      chk("cyc_dat", o_wb_dat, m.dat);
      chk("cyc_irq", {31'd0, o_irq}, {31'd0, m.match && m.ctrl[2]});
    end
  end

  // Called at posedge+1; returns at posedge+1 after one idle cycle following the ack.
  task automatic bus(input logic w, input int word, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd);
    int waited = 0;
    bit got = 0;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; wdat = d;
    adr = {$urandom_range(0, 1) ? 27'h123_4567 : 27'd0, 3'(word), 2'($urandom_range(0, 3))};
    rd = 32'd0;
    while (!got && waited < 8) begin
      @(posedge clk); #1;
      waited++;
      if (o_wb_ack) begin got = 1; rd = o_wb_dat; end
    end
    chk("ack_latency", 32'(waited), 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input int word, input logic [31:0] d);
    logic [31:0] unused_rd;
    bus(1'b1, word, d, 4'hF, unused_rd);
  endtask

  initial begin
    logic [31:0] rd;
    int waited;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_ack", {31'd0, o_wb_ack}, 32'd0);
    chk("rst_dat", o_wb_dat, 32'd0);
    chk("rst_irq", {31'd0, o_irq}, 32'd0);
    bus(1'b0, 3, 0, 4'hF, rd); chk("rst_compare", rd, 32'hFFFF_FFFF);
    bus(1'b0, 0, 0, 4'hF, rd); chk("rst_ctrl", rd, 32'd0);
    bus(1'b0, 2, 0, 4'hF, rd); chk("rst_count", rd, 32'd0);

    bus(1'b1, 2, 32'h1122_3344, 4'b0101, rd);
    bus(1'b0, 2, 0, 4'hF, rd); chk("lane_count", rd, 32'h0022_0044);
    bus(1'b1, 6, 32'hDEAD_BEEF, 4'hF, rd);
    bus(1'b0, 6, 0, 4'hF, rd); chk("unmapped_rd", rd, 32'd0);
    bus(1'b1, 1, 32'hABCD_1234, 4'hF, rd);
    bus(1'b0, 1, 0, 4'hF, rd); chk("prescale_rd", rd, 32'h0000_1234);

    wr(1, 3); wr(2, 0); wr(0, 1);
    repeat (38) @(posedge clk);
    #1 wr(0, 0);
    bus(1'b0, 2, 0, 4'hF, rd); chk("prescaled_count", rd, 32'd10);

    wr(1, 0); wr(2, 0); wr(3, 5); wr(4, 1); wr(0, 7);
    waited = 0;
    while (!o_irq && waited < 20) begin @(posedge clk); #1; waited++; end
    chk("irq_rise", {31'd0, o_irq}, 32'd1);
    bus(1'b0, 2, 0, 4'hF, rd); chk("reload_range", {31'd0, rd <= 32'd5}, 32'd1);
    wr(0, 6);
    chk("irq_held", {31'd0, o_irq}, 32'd1);
    wr(4, 1);
    chk("irq_cleared", {31'd0, o_irq}, 32'd0);
    wr(0, 7);
    repeat (10) @(posedge clk);
    #1 chk("irq_before_reset", {31'd0, o_irq}, 32'd1);

    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'd8;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_ack", {31'd0, o_wb_ack}, 32'd0);
    chk("async_dat", o_wb_dat, 32'd0);
    chk("async_irq", {31'd0, o_irq}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus(1'b0, 3, 0, 4'hF, rd); chk("post_rst_compare", rd, 32'hFFFF_FFFF);
    bus(1'b0, 4, 0, 4'hF, rd); chk("post_rst_status", rd, 32'd0);

    wr(0, 1); wr(2, 100);
    bus(1'b0, 2, 0, 4'hF, rd); chk("count_collision", rd, 32'd101);
    wr(0, 0);
    wr(1, 1); wr(2, 50); wr(3, 50); wr(4, 1); wr(0, 1); wr(4, 1);
    wr(0, 0);
    bus(1'b0, 4, 0, 4'hF, rd); chk("clear_collision", rd, 32'd1);
    wr(4, 1);
    bus(1'b0, 4, 0, 4'hF, rd); chk("status_clear", rd, 32'd0);

    wr(1, 0); wr(2, 32'hFFFF_FFFE); wr(3, 3); wr(4, 1); wr(0, 1);
    repeat (6) @(posedge clk);
    #1 wr(0, 0);
    bus(1'b0, 2, 0, 4'hF, rd); chk("wrap_count", rd, 32'd6);
    bus(1'b0, 4, 0, 4'hF, rd); chk("wrap_match", rd, 32'd1);

    for (int i = 0; i < 3000; i++) begin
      cyc  = ($urandom_range(0, 9) != 0);
      stb  = ($urandom_range(0, 3) != 0);
      we   = $urandom_range(0, 1);
      sel  = 4'($urandom);
      adr  = $urandom;
      wdat = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 7)) : $urandom;
      if (i % 500 == 250) wdat = 32'hFFFF_FFFD;
      @(posedge clk); #1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (4) @(posedge clk);
    #1 $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_timer_slave.md
# wb_timer_slave

Wishbone classic slave implementing a 32-bit prescaled timer with compare match, auto-reload and a level interrupt. It is the responder end of the CPU's data-side Wishbone bus: the CPU's load/store unit issues single read/write cycles, and this block decodes them, acknowledges them and updates or returns its memory-mapped registers. Address base decoding is done by the interconnect; this block uses only `i_wb_adr[4:2]`.

## Interface

Parameters:
- `PRESCALE_WIDTH`, default 16: width of the PRESCALE register and the internal prescaler counter.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `i_wb_cyc`  input  1  bus cycle valid.
- `i_wb_stb`  input  1  strobe; a request is `i_wb_cyc && i_wb_stb`.
- `i_wb_we`  input  1  1 = write, 0 = read.
- `i_wb_sel`  input  4  byte enables for writes; bit n covers data bits [8n+7:8n].
- `i_wb_adr`  input  32  byte address; only [4:2] are decoded.
- `i_wb_dat`  input  32  write data.
- `o_wb_dat`  output  32  read data, valid only while `o_wb_ack` is high.
- `o_wb_ack`  output  1  single-cycle acknowledge.
- `o_irq`  output  1  interrupt, level: `STATUS.match && CTRL.irq_en`.

## Operation

- Register map (word offset `i_wb_adr[4:2]`):
  - 0 CTRL: bit0 `enable`, bit1 `auto_reload`, bit2 `irq_en`; other bits read 0.
  - 1 PRESCALE: [PRESCALE_WIDTH-1:0]; upper bits read 0.
  - 2 COUNT: 32-bit read/write.
  - 3 COMPARE: 32-bit read/write.
  - 4 STATUS: bit0 `match`; write 1 to clear, write 0 has no effect.
  - 5-7: read 0; writes are ignored but still acknowledged.
- Writes honour `i_wb_sel` byte by byte. For STATUS, the clear applies only if `i_wb_sel[0]` is set.
- Prescaler:
  - While `enable` is set, the internal counter `pcnt` counts 0..PRESCALE.
  - When `pcnt == PRESCALE`, `pcnt` returns to 0 and a one-cycle `tick` is generated. PRESCALE = 0 therefore gives a tick every cycle.
  - While `enable` is clear, `pcnt` is held at 0, there is no tick, and COUNT holds its value.
  - Any accepted write to PRESCALE resets `pcnt` to 0.
- On tick:
  - If COUNT == COMPARE: set `match`, then COUNT <= 0 if `auto_reload`, else COUNT <= COUNT + 1.
  - Otherwise COUNT <= COUNT + 1.
  - COUNT wraps from 0xFFFF_FFFF to 0 with no flag.
- Simultaneous events:
  - A bus write to COUNT in the same cycle as a tick: the bus value wins and the tick increment is lost.
  - A STATUS clear in the same cycle as a new match: set wins, and `match` stays 1.
  - A write to COMPARE takes effect for comparisons from the next edge onward.

## Timing

- Reset (asynchronous assert; release is synchronous to `clk` at the system level):
  - CTRL = 0, PRESCALE = 0, COUNT = 0, COMPARE = 0xFFFF_FFFF, `match` = 0, `pcnt` = 0.
  - `o_wb_ack` = 0, `o_wb_dat` = 0, `o_irq` = 0.
- Handshake:
  - A request is accepted at a rising edge where `i_wb_cyc && i_wb_stb && !o_wb_ack`.
  - `o_wb_ack` rises after that edge and is high for exactly one cycle. Latency is 1 cycle, with no wait states.
  - Back-to-back requests with the strobe held high are acked every other cycle.
  - A master that drops `i_wb_cyc` before ack leaves no side effects, because nothing is accepted until the sampling edge.
- Writes update the register at the accepting edge.
- Read data is sampled at the accepting edge and reflects register values before that edge's updates.
- `o_wb_dat` is 0 whenever `o_wb_ack` is low or the acked cycle was a write.
- `o_irq` is derived from registered state, so it is glitch-free. It rises the cycle after the tick edge that sets `match`.
- Reset asserted mid-transaction: ack and all state clear immediately, and the pending transaction is dropped.

## Test plan

- **Reset:** drive `rst_n` = 0 mid-count → all outputs 0 asynchronously; read COMPARE after release → 0xFFFF_FFFF, ack exactly 1 cycle after the request edge.
- **Byte-lane write:** write COUNT = 0x1122_3344 with sel = 4'b0101 over 0 → readback 0x0022_0044; read offset 6 → 0, acked.
- **Prescaled count:** PRESCALE = 3, CTRL = 1 → COUNT increments once every 4 cycles; after 40 cycles COUNT = 10 (±1 for the enable edge).
- **Auto-reload with interrupt:** PRESCALE = 0, COMPARE = 5, CTRL = 0b111 → COUNT sequence 0..5,0..5; `match` is set when COUNT = 5 ticks; `o_irq` goes high and stays high until STATUS is written with 0x1, then drops.
- **Collisions:** write COUNT = 100 on a tick cycle → COUNT = 100 next cycle. Clear STATUS on the same edge as a new match → `match` stays 1.
- **Wrap without reload:** COUNT = 0xFFFF_FFFE, COMPARE = 3, `auto_reload` = 0, PRESCALE = 0 → sequence 0xFFFF_FFFF, 0, 1, ...; `match` is set when COUNT = 3 ticks and COUNT continues to 4.
